// File: rtl/serial_line_sched_if.sv
// serial_line_sched_if: requester-side bus of the serial line scheduler (requests, operands, grant/ack, result).
interface serial_line_sched_if;
  logic       req0;
  logic       req1;
  logic [7:0] opa0;
  logic [7:0] opb0;
  logic [7:0] opa1;
  logic [7:0] opb1;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic [7:0] res;
  logic       ovf;
  logic       busy;
  modport master (output req0, req1, opa0, opb0, opa1, opb1, input gnt, ack, res, ovf, busy);
  modport slave  (input req0, req1, opa0, opb0, opa1, opb1, output gnt, ack, res, ovf, busy);
endinterface

// File: rtl/serial_line_sched.sv
// serial_line_sched: arbitrates two requesters onto a shared bit-serial unit and collects its 8-bit result.
// Define SERIAL_SCHED_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module serial_line_sched (
  input  logic                 clock,
  input  logic                 reset,
  serial_line_sched_if.slave   bus,
  output logic                 line1,
  output logic                 line2,
  output logic                 unit_rst,
  input  logic                 outp,
  input  logic                 overflw
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DRAIN, DONE} state_t;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0] gnt_q, gnt_d, ack_q, ack_d;
  logic       ovf_q, ovf_d, line1_q, line1_d, line2_q, line2_d;
  logic       unit_rst_q, unit_rst_d, busy_q, busy_d;
  logic       win, cap;
`ifdef SERIAL_SCHED_RR_EN
  logic       ptr_q, ptr_d;
  assign win = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
`else
  assign win = ~bus.req0;
`endif
  // the unit's output lags the lines by one cycle, so SHIFT cycle 0 has nothing to capture yet
  assign cap = (state_q == SHIFT && cnt_q != 3'd0) || state_q == DRAIN;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = cap ? {outp, res_q[7:1]} : res_q;
    ovf_d      = ovf_q | (cap & overflw);
    gnt_d      = gnt_q;
    ack_d      = 2'b00;
    line1_d    = 1'b0;
    line2_d    = 1'b0;
    unit_rst_d = 1'b0;
    busy_d     = 1'b1;
`ifdef SERIAL_SCHED_RR_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d    = LOAD;
          sel_d      = win;
          a_d        = win ? bus.opa1 : bus.opa0;
          b_d        = win ? bus.opb1 : bus.opb0;
          gnt_d      = win ? 2'b10 : 2'b01;
          unit_rst_d = 1'b1;
          res_d      = 8'h00;
          ovf_d      = 1'b0;
          cnt_d      = 3'd0;
        end else begin
          gnt_d  = 2'b00;
          busy_d = 1'b0;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        line1_d = a_q[0];
        line2_d = b_q[0];
      end
      SHIFT: begin
        if (cnt_q == 3'd7) state_d = DRAIN;
        else begin
          cnt_d   = cnt_q + 3'd1;
          line1_d = a_q[cnt_d];
          line2_d = b_q[cnt_d];
        end
      end
      DRAIN: begin
        state_d = DONE;
        ack_d   = sel_q ? 2'b10 : 2'b01;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        busy_d  = 1'b0;
`ifdef SERIAL_SCHED_RR_EN
        ptr_d   = ~sel_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sel_q      <= 1'b0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      res_q      <= 8'h00;
      ovf_q      <= 1'b0;
      gnt_q      <= 2'b00;
      ack_q      <= 2'b00;
      line1_q    <= 1'b0;
      line2_q    <= 1'b0;
      unit_rst_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef SERIAL_SCHED_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      a_q        <= a_d;
      b_q        <= b_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      line1_q    <= line1_d;
      line2_q    <= line2_d;
      unit_rst_q <= unit_rst_d;
      busy_q     <= busy_d;
`ifdef SERIAL_SCHED_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end
  assign bus.gnt  = gnt_q;
  assign bus.ack  = ack_q;
  assign bus.res  = res_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign line1    = line1_q;
  assign line2    = line2_q;
  assign unit_rst = unit_rst_q;
endmodule

// File: tb/tb_serial_line_sched.sv
// tb_serial_line_sched: scoreboard bench for serial_line_sched with a serial-adder unit attached.
module tb_serial_line_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic line1, line2, unit_rst;
  logic outp = 1'b0;
  logic c_u = 1'b0;
  logic ovr = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  int lat;
  typedef struct {logic [1:0] g; logic [7:0] a; logic [7:0] b; logic [7:0] r; logic o;} exp_t;
  exp_t exp_q[$];
  exp_t cur, last;
  int ph = -1;
  bit rel = 1'b1;
`ifdef SERIAL_SCHED_RR_EN
  bit ptr = 1'b0;
`endif

  serial_line_sched_if bus();
  serial_line_sched dut (.clock(clk), .reset(rst_n), .bus(bus), .line1(line1), .line2(line2),
                         .unit_rst(unit_rst), .outp(outp), .overflw(c_u | ovr));

  always #5 clk = ~clk;

  // shared unit: bit-serial adder with registered sum bit and carry
  always @(posedge clk) begin
    if (unit_rst) {c_u, outp} <= 2'b00;
    else {c_u, outp} <= {1'b0, line1} + {1'b0, line2} + {1'b0, c_u};
  end

  function automatic bit carry_any(input logic [7:0] a, input logic [7:0] b);
    for (int k = 1; k <= 8; k++)
      if ((int'(a) % (1 << k)) + (int'(b) % (1 << k)) >= (1 << k)) return 1'b1;
    return 1'b0;
  endfunction

  function void chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h (phase %0d)", nm, $time, act, want, ph);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = -1;
      rel = 1'b1;
      chk("rst_gnt", 16'(bus.gnt), 16'h0);
      chk("rst_ack", 16'(bus.ack), 16'h0);
      chk("rst_res", 16'(bus.res), 16'h0);
      chk("rst_ovf", 16'(bus.ovf), 16'h0);
      chk("rst_busy", 16'(bus.busy), 16'h0);
      chk("rst_lines", {14'h0, line1, line2}, 16'h0);
      chk("rst_unit_rst", 16'(unit_rst), 16'h1);
    end else begin
      if (ph >= 0) ph = (ph == 11) ? -1 : ph + 1;
      if (ph == -1 && bus.gnt != 2'b00) ph = 0;
      if (ph >= 0 && ph <= 10 && exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_frame at %0t: got gnt %b expected no frame", $time, bus.gnt);
        ph = -1;
      end else if (ph >= 0 && ph <= 10) begin
        cur = exp_q[0];
        chk("gnt", 16'(bus.gnt), 16'(cur.g));
        chk("busy", 16'(bus.busy), 16'h1);
        chk("ack", 16'(bus.ack), ph == 10 ? 16'(cur.g) : 16'h0);
        if (ph == 0) begin
          chk("load_unit_rst", 16'(unit_rst), 16'h1);
          chk("load_res", 16'(bus.res), 16'h0);
          chk("load_ovf", 16'(bus.ovf), 16'h0);
        end else if (ph <= 8) begin
          chk("line1", 16'(line1), 16'(cur.a[ph-1]));
          chk("line2", 16'(line2), 16'(cur.b[ph-1]));
          chk("shift_unit_rst", 16'(unit_rst), 16'h0);
        end else begin
          chk("drain_lines", {14'h0, line1, line2}, 16'h0);
        end
        if (ph == 10) begin
          chk("res", 16'(bus.res), 16'(cur.r));
          chk("ovf", 16'(bus.ovf), 16'(cur.o));
          last = cur;
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_gnt", 16'(bus.gnt), 16'h0);
        chk("idle_ack", 16'(bus.ack), 16'h0);
        chk("idle_busy", 16'(bus.busy), 16'h0);
        chk("idle_lines", {14'h0, line1, line2}, 16'h0);
        if (!rel) chk("idle_unit_rst", 16'(unit_rst), 16'h0);
        if (ph == 11) begin
          chk("hold_res", 16'(bus.res), 16'(last.r));
          chk("hold_ovf", 16'(bus.ovf), 16'(last.o));
        end
      end
      rel = 1'b0;
    end
  end

  // issue one request pattern; abort_at > 0 pulses reset in that cycle after LOAD
  task automatic frame(input logic r0, input logic r1, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1, input bit scr, input bit frc,
                       input int abort_at, output int l);
    exp_t e;
    logic w;
    bus.req0 = r0;
    bus.req1 = r1;
    bus.opa0 = a0;
    bus.opb0 = b0;
    bus.opa1 = a1;
    bus.opb1 = b1;
`ifdef SERIAL_SCHED_RR_EN
    w = (r0 && r1) ? ptr : r1;
    ptr = !w;
`else
    w = !r0;
`endif
    e.g = w ? 2'b10 : 2'b01;
    e.a = w ? a1 : a0;
    e.b = w ? b1 : b0;
    e.r = e.a + e.b;
    e.o = carry_any(e.a, e.b) | frc;
    exp_q.push_back(e);
    l = 0;
    do begin
      @(posedge clk); #1;
      l++;
    end while (bus.gnt == 2'b00 && l < 30);
    if (bus.gnt == 2'b00) begin
      n_vec++;
      n_bad++;
      $display("FAIL load_timeout: got no grant after %0d cycles expected one within 2", l);
      return;
    end
    if (scr) begin
      bus.opa0 = 8'($urandom);
      bus.opb0 = 8'($urandom);
      bus.opa1 = 8'($urandom);
      bus.opb1 = 8'($urandom);
      bus.req0 = 1'($urandom);
      bus.req1 = 1'($urandom);
    end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == abort_at) begin
        rst_n = 1'b0;
        void'(exp_q.pop_back());
`ifdef SERIAL_SCHED_RR_EN
        ptr = 1'b0;
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      ovr = frc && k == 9;
    end
    if (w) bus.req1 = 1'b0;
    else bus.req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.opa0 = 8'h00;
    bus.opb0 = 8'h00;
    bus.opa1 = 8'h00;
    bus.opb1 = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.req0 = 1'($urandom);
      bus.req1 = 1'($urandom);
      bus.opa0 = 8'($urandom);
      bus.opb0 = 8'($urandom);
      bus.opa1 = 8'($urandom);
      bus.opb1 = 8'($urandom);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    frame(1'b1, 1'b0, 8'h00, 8'h00, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, lat);
    frame(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'hA5, 8'h3C, 1'b0, 1'b0, 0, lat);
    for (int i = 0; i < 3; i++)
      frame(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, lat);
    frame(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0, lat);
    frame(1'b1, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 0, lat);
    frame(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'h00, 8'h00, 1'b0, 1'b0, 5, lat);
    frame(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, lat);
    chk("reload_latency", 16'(lat), 16'h1);
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(1, 3));
      frame(r[0], r[1], 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'b0, 0, lat);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_line_sched.md
SERIAL_LINE_SCHED -- requirements
Module: serial_line_sched

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; asserted at 0
- req0, req1  in  1  frame request from requester 0 or 1; held high until that requester's ack
- opa0, opb0, opa1, opb1  in  8  operand pair for each requester
- gnt  out  2  one-hot grant; bit n = requester n is being served
- ack  out  2  one-cycle completion pulse per requester
- res  out  8  serial result word, LSB = first captured bit
- ovf  out  1  sticky overflow flag for the last completed frame
- busy  out  1  high in every state except IDLE
- line1, line2  out  1  serial operand bits driven to the shared serial unit
- unit_rst  out  1  active-high synchronous reset to the shared serial unit
- outp, overflw  in  1  registered outputs of the shared serial unit

Function
REQ-002 The FSM SHALL have five states: IDLE, LOAD, SHIFT, DRAIN, DONE.
REQ-003 IDLE: with any req high, the FSM SHALL go to LOAD on the next edge; otherwise it SHALL stay in IDLE.
REQ-004 Grant selection SHALL happen in IDLE. With one req high, that requester SHALL win. With both high, the winner SHALL follow REQ-016.
REQ-005 LOAD (1 cycle):
- gnt = winner;
- the winner's opa/opb SHALL be latched into internal shift registers;
- unit_rst = 1; res and ovf SHALL be cleared; bit counter = 0.
REQ-006 SHIFT (exactly 8 cycles, counter 0..7):
- line1 = opa[cnt], line2 = opb[cnt], LSB first; unit_rst = 0.
REQ-007 Operand or req changes after LOAD SHALL NOT affect the frame in progress.
REQ-008 Capture: because outp lags line1/line2 by one cycle, outp SHALL be sampled in SHIFT cycles 1..7 and in DRAIN. It SHALL be shifted into res MSB-first, so that after DRAIN res[0] holds the response to bit 0.
REQ-009 DRAIN (1 cycle): line1 = line2 = 0; the FSM SHALL go to DONE.
REQ-010 ovf SHALL be set if overflw is 1 on any capture sample of REQ-008, and SHALL stay set until the next LOAD.
REQ-011 DONE (1 cycle):
- ack[winner] = 1, all other ack bits 0;
- gnt SHALL stay asserted;
- the next state SHALL be IDLE (minimum one IDLE cycle between frames).
REQ-012 Timing, with LOAD = cycle 0: ack SHALL be high in cycle 10, and gnt SHALL drop in cycle 11.
REQ-013 res and ovf SHALL hold their value from DONE until the next LOAD.
REQ-014 If a requester drops req mid-frame, the frame SHALL still complete and be acked.
REQ-015 In IDLE, line1 = line2 = 0, unit_rst = 0, gnt = 00.

Reset
REQ-017 While reset = 0 the block SHALL asynchronously force:
- state = IDLE;
- gnt = 00, ack = 00, res = 0x00, ovf = 0, busy = 0;
- line1 = line2 = 0, unit_rst = 1;
- RR pointer = requester 0.
REQ-018 A reset during any non-IDLE state SHALL abort the frame with no ack. Operation SHALL restart from IDLE on the first edge after reset returns to 1.

Configuration
REQ-016 The macro SERIAL_SCHED_RR_EN SHALL control arbitration:
- Defined: round-robin. A 1-bit pointer names the preferred requester. After each DONE, the pointer SHALL move to the requester that was not served.
- Undefined: fixed priority. req0 SHALL always win a tie, and no pointer register exists.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset-hold: reset = 0 with random inputs -> all outputs at the REQ-017 values, unit_rst = 1.
- req0 only, opa0 = 0x00, opb0 = 0x00, with the shared serial unit attached -> line1/line2 = 0 for 8 cycles, ack = 01 in cycle 10, res = 0x00, ovf = 0.
- req1 only, opa1 = 0xA5, opb1 = 0x3C -> line1 sequence 1,0,1,0,0,1,0,1 and line2 sequence 0,0,1,1,1,1,0,0 over SHIFT; ack = 10 in cycle 10.
- req0 and req1 high together for 3 frames, with SERIAL_SCHED_RR_EN defined -> grant order 0,1,0. With the macro undefined -> grant order 0,0,0.
- overflw forced to 1 in DRAIN only -> ovf = 1 at DONE, then ovf = 0 after the next LOAD.
- reset pulsed low in SHIFT cycle 4 -> no ack, and state is IDLE on release. A held req0 -> a new LOAD on the next edge, and a full 8-bit frame follows.
